// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: CPU clock-enable controller for single-step, burst,
// paced and full-speed execution with a debounced button and breakpoint.
module clk_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SLOW_DIV        = 50000000,
    parameter int FAST_DIV        = 5000000,
    parameter int BURST_W         = 8,
    parameter int ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic [1:0]        mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              cpu_ce,
    output logic              btn_pulse,
    output logic              running,
    output logic              halted
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int RATE_W  = $clog2(DIV_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RATE_W-1:0] SLOW_LAST = RATE_W'(SLOW_DIV - 1);
    localparam logic [RATE_W-1:0] FAST_LAST = RATE_W'(FAST_DIV - 1);

    localparam logic [1:0] M_STEP = 2'b00;
    localparam logic [1:0] M_SLOW = 2'b01;
    localparam logic [1:0] M_FAST = 2'b10;
    localparam logic [1:0] M_FULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_RUN,
        S_HALT
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_btn_pulse;

    logic [1:0]        r_mode_q;
    logic [RATE_W-1:0] r_rate_cnt;
    logic [RATE_W-1:0] w_rate_last;
    logic              w_rate_en;
    logic              w_mode_chg;
    logic              w_tick;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic              w_cpu_ce;
    logic              w_bp_hit;

    // Two-flop synchronizer for the raw (active-low) button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYCLES differing samples;
    // a flip to 0 (press) emits a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level  <= 1'b1;
            r_db_cnt    <= '0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_pulse <= 1'b0;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level  <= r_sync2;
                r_db_cnt    <= '0;
                r_btn_pulse <= ~r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Rate divider selection; only slow and fast modes are paced.
    always_comb begin
        w_rate_last = '0;
        w_rate_en   = 1'b0;
        case (mode)
            M_SLOW: begin
                w_rate_last = SLOW_LAST;
                w_rate_en   = 1'b1;
            end
            M_FAST: begin
                w_rate_last = FAST_LAST;
                w_rate_en   = 1'b1;
            end
            default: begin
                w_rate_last = '0;
                w_rate_en   = 1'b0;
            end
        endcase
    end

    assign w_mode_chg = (mode != r_mode_q);
    assign w_tick     = w_rate_en && !w_mode_chg &&
                        (r_rate_cnt == w_rate_last);

    // Previous mode, used to detect a mode change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= M_STEP;
        end else begin
            r_mode_q <= mode;
        end
    end

    // Rate counter: 0..DIV-1, cleared on any mode change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rate_cnt <= '0;
        end else if (w_mode_chg || !w_rate_en) begin
            r_rate_cnt <= '0;
        end else if (r_rate_cnt == w_rate_last) begin
            r_rate_cnt <= '0;
        end else begin
            r_rate_cnt <= r_rate_cnt + 1'b1;
        end
    end

    assign w_bp_hit = bp_en && (pc_addr == bp_addr);

    // Next-state and cpu_ce decode for the step/run controller.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_cpu_ce    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_pulse) begin
                    if (mode == M_STEP) begin
                        w_state_nxt = S_BURST;
                        w_burst_nxt = (burst_len == '0) ?
                                      BURST_W'(1) : burst_len;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_BURST: begin
                w_cpu_ce = 1'b1;
                if (r_burst_cnt <= BURST_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_burst_nxt = '0;
                end else begin
                    w_burst_nxt = r_burst_cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (mode == M_STEP) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_mode_chg &&
                             ((mode == M_FULL) || w_tick)) begin
                    if (w_bp_hit) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_cpu_ce = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (mode == M_STEP) begin
                    w_state_nxt = S_IDLE;
                end else if (r_btn_pulse) begin
                    w_cpu_ce    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    // Controller state and remaining burst count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    assign cpu_ce    = w_cpu_ce;
    assign btn_pulse = r_btn_pulse;
    assign running   = (r_state == S_RUN);
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: directed checks of clk_step_ctrl with short
// debounce and divider settings.
module tb_clk_step_ctrl;

    logic        clk;
    logic        rst;
    logic        btn;
    logic [1:0]  mode;
    logic [7:0]  burst_len;
    logic        bp_en;
    logic [11:0] bp_addr;
    logic [11:0] pc_addr;
    logic        cpu_ce;
    logic        btn_pulse;
    logic        running;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc_n;
    int ce_cnt;
    int bp_cnt;
    int last_ce;
    int bad_gap;
    int run_len;
    int max_run;
    int halt_ce;
    int first_pulse;
    int found;
    logic ce_last = 1'b0;
    bit auto_pc = 1'b0;

    clk_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SLOW_DIV(10),
        .FAST_DIV(3),
        .BURST_W(8),
        .ADDR_W(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .mode(mode),
        .burst_len(burst_len),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc_addr(pc_addr),
        .cpu_ce(cpu_ce),
        .btn_pulse(btn_pulse),
        .running(running),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    task automatic clr();
        cyc_n       = 0;
        ce_cnt      = 0;
        bp_cnt      = 0;
        last_ce     = -1;
        bad_gap     = 0;
        run_len     = 0;
        max_run     = 0;
        halt_ce     = 0;
        first_pulse = -1;
    endtask

    // One clock cycle: model pc advance, then sample outputs mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_pc && ce_last) pc_addr = pc_addr + 12'd1;
        #1;
        cyc_n++;
        ce_last = cpu_ce;
        if (cpu_ce) begin
            ce_cnt++;
            if (last_ce >= 0 && (cyc_n - last_ce) != 3) bad_gap++;
            last_ce = cyc_n;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (halted) halt_ce++;
        end else begin
            run_len = 0;
        end
        if (btn_pulse) begin
            bp_cnt++;
            if (first_pulse < 0) first_pulse = cyc_n;
        end
    endtask

    task automatic press(input int low_n, input int high_n);
        btn = 1'b0;
        repeat (low_n) cyc();
        btn = 1'b1;
        repeat (high_n) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        btn       = 1'b1;
        mode      = 2'b00;
        burst_len = 8'd3;
        bp_en     = 1'b0;
        bp_addr   = 12'd0;
        pc_addr   = 12'd0;
        clr();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_ce", int'(cpu_ce), 0);
        chk("rst_btn_pulse", int'(btn_pulse), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_halted", int'(halted), 0);
        rst = 1'b0;
        repeat (3) cyc();

        // Step mode burst of 3
        clr();
        press(10, 15);
        chk("t1_pulses", bp_cnt, 1);
        chk_rng("t1_latency", first_pulse, 6, 8);
        chk("t1_ce_count", ce_cnt, 3);
        chk("t1_ce_consecutive", max_run, 3);
        chk("t1_idle_running", int'(running), 0);
        chk("t1_idle_halted", int'(halted), 0);

        // Short glitch is rejected
        clr();
        press(2, 12);
        chk("t2_pulses", bp_cnt, 0);
        chk("t2_ce_count", ce_cnt, 0);

        // Fast mode pacing
        mode = 2'b10;
        repeat (3) cyc();
        clr();
        press(8, 8);
        clr();
        repeat (30) cyc();
        chk("t3_ce_count", ce_cnt, 10);
        chk("t3_bad_gaps", bad_gap, 0);
        chk("t3_running", int'(running), 1);
        mode = 2'b00;
        #1;
        chk("t3_stop_ce", int'(cpu_ce), 0);
        cyc();
        chk("t3_stop_running", int'(running), 0);
        repeat (3) cyc();

        // Full speed into breakpoint, then single press out of HALT
        mode    = 2'b11;
        bp_addr = 12'h005;
        bp_en   = 1'b1;
        pc_addr = 12'd0;
        ce_last = 1'b0;
        auto_pc = 1'b1;
        repeat (3) cyc();
        clr();
        press(8, 8);
        chk("t4_ce_before_bp", ce_cnt, 5);
        chk("t4_pc_at_bp", int'(pc_addr), 5);
        chk("t4_halted", int'(halted), 1);
        mode = 2'b10;
        repeat (2) cyc();
        mode = 2'b11;
        repeat (2) cyc();
        chk("t4_halt_mode_chg", int'(halted), 1);
        chk("t4_halt_pc", int'(pc_addr), 5);
        clr();
        press(8, 4);
        chk("t4_halt_step_ce", halt_ce, 1);
        chk("t4_resume_running", int'(running), 1);
        mode = 2'b00;
        cyc();
        auto_pc = 1'b0;
        bp_en   = 1'b0;
        repeat (3) cyc();

        // Slow mode, leave to step mode on the tick cycle
        mode = 2'b01;
        repeat (3) cyc();
        clr();
        press(8, 2);
        found = 0;
        for (int i = 0; i < 25 && found == 0; i++) begin
            cyc();
            if (ce_last) found = 1;
        end
        chk("t5_tick_seen", found, 1);
        repeat (9) cyc();
        mode = 2'b00;
        #1;
        chk("t5_ce_suppressed", int'(cpu_ce), 0);
        cyc();
        chk("t5_idle_running", int'(running), 0);
        chk("t5_idle_halted", int'(halted), 0);
        clr();
        repeat (5) cyc();
        chk("t5_idle_ce", ce_cnt, 0);

        // Reset in the middle of a burst of 5
        burst_len = 8'd5;
        repeat (3) cyc();
        clr();
        btn = 1'b0;
        for (int i = 0; i < 20 && ce_cnt < 2; i++) cyc();
        chk("t6_two_pulses", ce_cnt, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        btn = 1'b1;
        #1;
        chk("t6_rst_ce", int'(cpu_ce), 0);
        chk("t6_rst_pulse", int'(btn_pulse), 0);
        chk("t6_rst_running", int'(running), 0);
        chk("t6_rst_halted", int'(halted), 0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        clr();
        repeat (15) cyc();
        chk("t6_post_ce", ce_cnt, 0);
        chk("t6_post_pulse", bp_cnt, 0);

        // Zero burst length behaves as one
        burst_len = 8'd0;
        clr();
        press(8, 8);
        chk("t7_burst0_ce", ce_cnt, 1);
        chk("t7_burst0_pulse", bp_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
